// File: rtl/cc_alu_if.sv
// cc_alu_if: ALU result bus from the execute-stage ALU to its consumers
interface cc_alu_if #(
  parameter int WIDTH = 64
);
  logic             e_valid;
  logic             e_set_cc;
  logic [3:0]       e_ifun;
  logic [WIDTH-1:0] alu_out;
  logic             alu_ovf;
  modport master (output e_valid, e_set_cc, e_ifun, alu_out, alu_ovf);
  modport slave  (input  e_valid, e_set_cc, e_ifun, alu_out, alu_ovf);
endinterface

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: Y86 execute-stage condition codes, Cnd evaluation and E->M register
module cc_cond_unit #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  cc_alu_if.slave          alu,
  input  logic             m_exc,
  input  logic             w_exc,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             e_cnd,
  output logic             e_ifun_err,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_valE,
  output logic             m_cnd
);
  logic lt, cc_we;
  assign lt    = cc_sf ^ cc_of;
  assign cc_we = alu.e_valid & alu.e_set_cc & ~m_exc & ~w_exc;
  // condition from the currently held flags, so a same-cycle set_cc sees old codes
  always_comb begin
    e_ifun_err = alu.e_valid & (alu.e_ifun > 4'd6);
    e_cnd = alu.e_ifun == 4'd0 ? 1'b1 :
            alu.e_ifun == 4'd1 ? lt | cc_zf :
            alu.e_ifun == 4'd2 ? lt :
            alu.e_ifun == 4'd3 ? cc_zf :
            alu.e_ifun == 4'd4 ? ~cc_zf :
            alu.e_ifun == 4'd5 ? ~lt :
            alu.e_ifun == 4'd6 ? ~lt & ~cc_zf : 1'b0;
  end
  // condition codes; exceptions in later stages suppress the update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {cc_zf, cc_sf, cc_of} <= CC_RESET;
    else if (cc_we) {cc_zf, cc_sf, cc_of} <= {alu.alu_out == '0, alu.alu_out[WIDTH-1], alu.alu_ovf};
  end
  // E->M pipeline register: bubble beats stall beats load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {m_valid, m_valE, m_cnd} <= '0;
    else if (m_bubble) {m_valid, m_valE, m_cnd} <= '0;
    else if (!m_stall) {m_valid, m_valE, m_cnd} <= {alu.e_valid, alu.alu_out, e_cnd};
  end
endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: directed and randomized checks of cc_cond_unit against a behavioural model
module tb_cc_cond_unit;
  localparam int W = 64;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};
  logic clk = 0, rst = 1;
  logic m_exc = 0, w_exc = 0, m_stall = 0, m_bubble = 0;
  logic cc_zf, cc_sf, cc_of, e_cnd, e_ifun_err, m_valid, m_cnd;
  logic [W-1:0] m_valE;
  int n_cmp = 0, n_fail = 0;
  logic mzf, msf, mof, mv, mc;
  logic [W-1:0] mval;

  cc_alu_if #(.WIDTH(W)) alu_bus ();

  cc_cond_unit #(.WIDTH(W), .CC_RESET(3'b100)) dut (
    .clk(clk), .rst(rst), .alu(alu_bus.slave),
    .m_exc(m_exc), .w_exc(w_exc), .m_stall(m_stall), .m_bubble(m_bubble),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .e_cnd(e_cnd), .e_ifun_err(e_ifun_err),
    .m_valid(m_valid), .m_valE(m_valE), .m_cnd(m_cnd)
  );

  always #5 clk = ~clk;

  // Y86 jump/cmov semantics: a signed "less than" exists when sign and overflow disagree
  function automatic logic cond(input logic [3:0] f, input logic z, input logic s, input logic o);
    logic less;
    less = (s != o);
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || z;
      4'd2: return less;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !less;
      4'd6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    {mzf, msf, mof} = 3'b100;
    {mv, mval, mc} = '0;
  endtask

  task automatic tick();
    logic nz, ns, no, nv, nc;
    logic [W-1:0] nval;
    {nz, ns, no} = {mzf, msf, mof};
    {nv, nval, nc} = {mv, mval, mc};
    if (alu_bus.e_valid && alu_bus.e_set_cc && !m_exc && !w_exc)
      {nz, ns, no} = {alu_bus.alu_out == 0, $signed(alu_bus.alu_out) < 0, alu_bus.alu_ovf};
    if (m_bubble) {nv, nval, nc} = '0;
    else if (!m_stall) {nv, nval, nc} = {alu_bus.e_valid, alu_bus.alu_out, cond(alu_bus.e_ifun, mzf, msf, mof)};
    @(posedge clk);
    {mzf, msf, mof} = {nz, ns, no};
    {mv, mval, mc} = {nv, nval, nc};
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] f, input logic [W-1:0] a, input logic o);
    alu_bus.e_valid = v; alu_bus.e_set_cc = s; alu_bus.e_ifun = f;
    alu_bus.alu_out = a; alu_bus.alu_ovf = o;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of, m_valid, m_valE, m_cnd} !== {3'b100, 1'b0, {W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b m_valid=%b m_valE=%h m_cnd=%b, want flags=100 others 0", {cc_zf, cc_sf, cc_of}, m_valid, m_valE, m_cnd);
    end
    drive(1, 1, 0, 64'h1234, 0);
    tick();
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of, m_valid, m_valE, m_cnd} !== {3'b100, 1'b0, {W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: flags=%b m_valid=%b m_valE=%h, want flags=100 m_valid=0 m_valE=0", {cc_zf, cc_sf, cc_of}, m_valid, m_valE);
    end
    rst = 0;
    model_reset();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_cc_update();
    drive(1, 1, 0, 0, 0);
    tick();
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      n_fail++;
      $display("FAIL cc_zero: flags=%b want 100", {cc_zf, cc_sf, cc_of});
    end
    drive(1, 1, 0, MSB, 1);
    tick();
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
      n_fail++;
      $display("FAIL cc_neg_ovf: flags=%b want 011", {cc_zf, cc_sf, cc_of});
    end
  endtask

  task automatic test_cond();
    logic [7:0] exp_cnd;
    exp_cnd = 8'b0001_0111;
    drive(1, 1, 0, MSB, 0);
    tick();
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
      n_fail++;
      $display("FAIL cond_setup: flags=%b want 010", {cc_zf, cc_sf, cc_of});
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 4'(i), 0, 0);
      #1;
      n_cmp++;
      if (e_cnd !== exp_cnd[i] || e_ifun_err !== (i == 7)) begin
        n_fail++;
        $display("FAIL cond_ifun%0d: e_cnd=%b err=%b want e_cnd=%b err=%b", i, e_cnd, e_ifun_err, exp_cnd[i], i == 7);
      end
    end
    drive(0, 0, 4'hf, 0, 0);
    #1;
    n_cmp++;
    if (e_cnd !== 1'b0 || e_ifun_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cond_invalid_ifun15: e_cnd=%b err=%b want 0 0", e_cnd, e_ifun_err);
    end
  endtask

  task automatic test_exc();
    drive(1, 1, 0, 0, 0);
    m_exc = 1;
    tick();
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of, m_valid} !== 4'b0101) begin
      n_fail++;
      $display("FAIL exc_m: flags=%b m_valid=%b want 010 1", {cc_zf, cc_sf, cc_of}, m_valid);
    end
    m_exc = 0; w_exc = 1;
    drive(1, 1, 0, 64'h77, 0);
    tick();
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b010 || m_valE !== 64'h77) begin
      n_fail++;
      $display("FAIL exc_w: flags=%b m_valE=%h want 010 77", {cc_zf, cc_sf, cc_of}, m_valE);
    end
    w_exc = 0;
    drive(0, 1, 0, 0, 0);
    tick();
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of, m_valid} !== 4'b0100) begin
      n_fail++;
      $display("FAIL invalid_no_cc: flags=%b m_valid=%b want 010 0", {cc_zf, cc_sf, cc_of}, m_valid);
    end
  endtask

  task automatic test_stall_bubble();
    drive(1, 0, 0, 64'h5, 0);
    tick();
    m_stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_bus.alu_out = {$urandom, $urandom};
      tick();
      n_cmp++;
      if (m_valE !== 64'h5 || m_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold%0d: m_valE=%h m_valid=%b want 5 1", i, m_valE, m_valid);
      end
    end
    m_bubble = 1;
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || m_valE !== '0 || m_cnd !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_over_stall: m_valid=%b m_valE=%h m_cnd=%b want 0 0 0", m_valid, m_valE, m_cnd);
    end
    m_stall = 0; m_bubble = 0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    exp = 3'b011;
    rst = 1; #2 rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3, (i == 0) ? 64'h0 : 64'h1, 0);
      #1;
      n_cmp++;
      if (e_cnd !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: e_cnd=%b want %b", i + 1, e_cnd, exp[i]);
      end
      tick();
    end
    n_cmp++;
    if (m_cnd !== 1'b0 || cc_zf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_final: m_cnd=%b zf=%b want 0 0", m_cnd, cc_zf);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = '0;
        1: a = {$urandom, $urandom} | MSB;
        default: a = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1), 4'($urandom_range(0, 9)), a, $urandom_range(0, 1));
      m_exc = $urandom_range(0, 7) == 0;
      w_exc = $urandom_range(0, 7) == 0;
      m_stall = $urandom_range(0, 5) == 0;
      m_bubble = $urandom_range(0, 7) == 0;
      #1;
      n_cmp++;
      if (e_cnd !== cond(alu_bus.e_ifun, mzf, msf, mof) || e_ifun_err !== (alu_bus.e_valid && alu_bus.e_ifun > 6)) begin
        n_fail++;
        $display("FAIL rand_cnd%0d: e_cnd=%b err=%b ifun=%0d want e_cnd=%b", i, e_cnd, e_ifun_err, alu_bus.e_ifun, cond(alu_bus.e_ifun, mzf, msf, mof));
      end
      tick();
      n_cmp++;
      if ({cc_zf, cc_sf, cc_of, m_valid, m_valE, m_cnd} !== {mzf, msf, mof, mv, mval, mc}) begin
        n_fail++;
        $display("FAIL rand_state%0d: flags=%b m=%b/%h/%b want flags=%b m=%b/%h/%b", i, {cc_zf, cc_sf, cc_of}, m_valid, m_valE, m_cnd, {mzf, msf, mof}, mv, mval, mc);
      end
    end
    m_exc = 0; w_exc = 0; m_stall = 0; m_bubble = 0;
  endtask

  initial begin
    test_reset();
    test_cc_update();
    test_cond();
    test_exc();
    test_stall_bubble();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
